cpu_mem_responder: RTL and testbench
====================================

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the word address width; the array holds 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, SHALL set the word width.
REQ-003 Parameter WBUF_DEPTH, default 4, SHALL set the write-buffer entry count (power of two, 2..16).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 read_mem  input  1  read request from the CPU.
REQ-007 mem_radrs  input  ADDR_W  read word address.
REQ-008 read_ready  output  1  high when a read request is accepted this cycle.
REQ-009 instruction_fetch  output  DATA_W  read data returned to the CPU.
REQ-010 rdata_valid  output  1  instruction_fetch holds new data this cycle.
REQ-011 write_mem  input  1  write request from the CPU.
REQ-012 mem_wadrs  input  ADDR_W  write word address.
REQ-013 result  input  DATA_W  write data.
REQ-014 write_ready  output  1  high when a write request is accepted this cycle.
REQ-015 init_done  output  1  high once post-reset array clear has completed.

Function
REQ-016 Array SHALL be single-port: at most one access (clear write, read, or buffer drain) per cycle.
REQ-017 After reset the block SHALL be in state INIT, writing zero to address 0,1,...,2**ADDR_W-1 on consecutive cycles, then SHALL enter state RUN and assert init_done.
REQ-018 In INIT, read_ready and write_ready SHALL be 0.
REQ-019 In RUN, a write is accepted (write_ready=1) when the write buffer is not full; accepted {mem_wadrs,result} SHALL enter the buffer FIFO in order.
REQ-020 Write acceptance SHALL NOT depend on a same-cycle drain freeing an entry (no full-buffer bypass).
REQ-021 Per-cycle arbitration in RUN: buffer full -> drain oldest entry, read_ready=0; else read_mem=1 -> serve read; else buffer non-empty -> drain oldest entry.
REQ-022 An accepted read SHALL produce rdata_valid=1 and instruction_fetch exactly one cycle after acceptance; otherwise rdata_valid=0 and instruction_fetch SHALL hold its last value.
REQ-023 Simultaneous accepted read and write to the same address: the read SHALL return the pre-write value; the write is ordered after the read.
REQ-024 Multiple buffered writes to one address SHALL drain in acceptance order (last write wins in the array).
REQ-025 Buffer occupancy SHALL never exceed WBUF_DEPTH; FIFO pointers SHALL wrap modulo WBUF_DEPTH.
REQ-026 Write data already in the buffer SHALL be visible to later reads per REQ-033/REQ-034.

Reset
REQ-027 reset assertion SHALL take effect immediately regardless of clk.
REQ-028 Reset values: instruction_fetch=0, rdata_valid=0, read_ready=0, write_ready=0, init_done=0, buffer empty, state INIT, clear address 0.
REQ-029 reset mid-INIT or mid-RUN SHALL discard all buffered writes and an in-flight read (no rdata_valid after reset release), then restart INIT from address 0.
REQ-030 Array contents SHALL NOT be assumed preserved across reset; INIT zeroes them.

Configuration
REQ-031 Macro MEM_FWD_EN SHALL select read-hit-in-buffer handling.
REQ-032 Hit definition: mem_radrs equals the address of any valid buffer entry.
REQ-033 With MEM_FWD_EN defined: a hitting read SHALL be accepted normally and return the newest matching buffer entry's data, latency per REQ-022.
REQ-034 Without MEM_FWD_EN: a hitting read SHALL get read_ready=0 and the buffer SHALL drain, one entry per cycle, until no entry matches; the read is then accepted from the array.

Verification
REQ-035 Reset release -> init_done=0 for exactly 2048 cycles (ADDR_W=11), then 1; read of 0x7FF -> instruction_fetch=0x00000000 one cycle later.
REQ-036 Write 0x12345678 to 0x010, then 3 idle cycles, read 0x010 -> rdata_valid=1 with 0x12345678 one cycle after read_ready=1.
REQ-037 Continuous reads with 5 back-to-back writes (WBUF_DEPTH=4) -> 5th write sees write_ready=0 until a forced drain; read_ready=0 that cycle; all 5 writes land in order.
REQ-038 Write 0xAAAA0001 then 0xAAAA0002 to 0x020, immediate read 0x020 -> returns 0xAAAA0002 next cycle with MEM_FWD_EN; without it read_ready=0 for 2 cycles, then 0xAAAA0002.
REQ-039 Same-cycle read and write to 0x030 (array holds 0x0) with new data 0xFFFF0000 -> read returns 0x0; next read returns 0xFFFF0000.
REQ-040 Assert reset with 3 buffered writes and a read in flight -> rdata_valid stays 0, INIT restarts at address 0, later reads of those addresses return 0.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// Single-port word memory: zeroed after reset, posted CPU writes through an in-order buffer, 1-cycle reads.
// Reads stall only when the buffer is full or, without MEM_FWD_EN, when they hit a buffered address.
module cpu_mem_responder #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_mem,
  input  logic [ADDR_W-1:0] mem_radrs,
  output logic              read_ready,
  output logic [DATA_W-1:0] instruction_fetch,
  output logic              rdata_valid,
  input  logic              write_mem,
  input  logic [ADDR_W-1:0] mem_wadrs,
  input  logic [DATA_W-1:0] result,
  output logic              write_ready,
  output logic              init_done
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int WORDS = 1 << ADDR_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_addr;

  logic [DATA_W-1:0] mem [WORDS];

  logic [ADDR_W-1:0] wb_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data [WBUF_DEPTH];
  logic [PTR_W-1:0]  wb_rd_ptr;
  logic [PTR_W-1:0]  wb_wr_ptr;
  logic [PTR_W:0]    wb_cnt;

  logic              run;
  logic              wb_full;
  logic              wb_empty;
  logic              rd_hit;
  logic [DATA_W-1:0] hit_data;
  logic              rd_block;
  logic              wr_acc;
  logic              drain;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign run      = (state == ST_RUN);
  assign wb_full  = (wb_cnt == (PTR_W+1)'(WBUF_DEPTH));
  assign wb_empty = (wb_cnt == '0);

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    rd_hit   = 1'b0;
    hit_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (((PTR_W+1)'(i) < wb_cnt) &&
          (wb_addr[wb_rd_ptr + PTR_W'(i)] == mem_radrs)) begin
        rd_hit   = 1'b1;
        hit_data = wb_data[wb_rd_ptr + PTR_W'(i)];
      end
    end
  end

`ifdef MEM_FWD_EN
  assign rd_block = 1'b0;
`else
  assign rd_block = rd_hit;
`endif

  // A full buffer blocks writes even if it drains this cycle.
  assign write_ready = run && !wb_full;
  assign read_ready  = run && !wb_full && read_mem && !rd_block;
  assign wr_acc      = write_mem && write_ready;
  assign drain       = run && !wb_empty && !read_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      clr_addr  <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      clr_addr <= clr_addr + 1'b1;
      if (clr_addr == {ADDR_W{1'b1}}) begin
        state     <= ST_RUN;
        init_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_rd_ptr <= '0;
      wb_wr_ptr <= '0;
      wb_cnt    <= '0;
    end else begin
      if (wr_acc) wb_wr_ptr <= wb_wr_ptr + 1'b1;
      if (drain)  wb_rd_ptr <= wb_rd_ptr + 1'b1;
      case ({wr_acc, drain})
        2'b10:   wb_cnt <= wb_cnt + 1'b1;
        2'b01:   wb_cnt <= wb_cnt - 1'b1;
        default: wb_cnt <= wb_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      wb_addr[wb_wr_ptr] <= mem_wadrs;
      wb_data[wb_wr_ptr] <= result;
    end
  end

  // The single array port is shared by the clear sweep and buffer drains; reads never coincide with either.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (state == ST_INIT) begin
      mem_we = 1'b1;
      mem_wa = clr_addr;
    end else if (drain) begin
      mem_we = 1'b1;
      mem_wa = wb_addr[wb_rd_ptr];
      mem_wd = wb_data[wb_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction_fetch <= '0;
      rdata_valid       <= 1'b0;
    end else begin
      rdata_valid <= read_ready;
      if (read_ready) begin
`ifdef MEM_FWD_EN
        instruction_fetch <= rd_hit ? hit_data : mem[mem_radrs];
`else
        instruction_fetch <= mem[mem_radrs];
`endif
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomised and directed bench for cpu_mem_responder against a queue-based memory model.
module tb_cpu_mem_responder;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int D  = 4;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          read_mem = 1'b0;
  logic          write_mem = 1'b0;
  logic [AW-1:0] mem_radrs = '0;
  logic [AW-1:0] mem_wadrs = '0;
  logic [DW-1:0] result = '0;
  logic          read_ready;
  logic          rdata_valid;
  logic          write_ready;
  logic          init_done;
  logic [DW-1:0] instruction_fetch;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] m_mem [NW];
  bit            m_run = 1'b0;
  int            m_clr = 0;
  logic          m_rv = 1'b0;
  logic [DW-1:0] m_if = '0;
  bit            m_hit;
  logic [DW-1:0] m_fd;
  logic          e_rr;
  logic          e_wr;

  cpu_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(D)) dut (
    .clk               (clk),
    .reset             (reset),
    .read_mem          (read_mem),
    .mem_radrs         (mem_radrs),
    .read_ready        (read_ready),
    .instruction_fetch (instruction_fetch),
    .rdata_valid       (rdata_valid),
    .write_mem         (write_mem),
    .mem_wadrs         (mem_wadrs),
    .result            (result),
    .write_ready       (write_ready),
    .init_done         (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: clear sweep, then a FIFO of posted writes arbitrated against reads.
  always @(negedge clk) begin
    if (reset) begin
      chkb("rst_read_ready", read_ready, 1'b0);
      chkb("rst_write_ready", write_ready, 1'b0);
      chkb("rst_rdata_valid", rdata_valid, 1'b0);
      chkb("rst_init_done", init_done, 1'b0);
      chk("rst_instruction_fetch", instruction_fetch, '0);
      mq.delete();
      m_run = 1'b0;
      m_clr = 0;
      m_rv  = 1'b0;
      m_if  = '0;
    end else begin
      chkb("init_done", init_done, m_run);
      chkb("rdata_valid", rdata_valid, m_rv);
      chk("instruction_fetch", instruction_fetch, m_if);
      if (!m_run) begin
        chkb("init_read_ready", read_ready, 1'b0);
        chkb("init_write_ready", write_ready, 1'b0);
        m_rv = 1'b0;
        m_mem[m_clr] = '0;
        if (m_clr == NW - 1) m_run = 1'b1;
        m_clr++;
      end else begin
        m_hit = 1'b0;
        m_fd  = '0;
        foreach (mq[i]) begin
          if (mq[i].a == mem_radrs) begin
            m_hit = 1'b1;
            m_fd  = mq[i].d;
          end
        end
        e_wr = (mq.size() < D);
`ifdef MEM_FWD_EN
        e_rr = (mq.size() < D) && read_mem;
`else
        e_rr = (mq.size() < D) && read_mem && !m_hit;
`endif
        chkb("read_ready", read_ready, e_rr);
        chkb("write_ready", write_ready, e_wr);
        m_rv = e_rr;
        if (e_rr) m_if = m_hit ? m_fd : m_mem[mem_radrs];
        if (!e_rr && mq.size() > 0) begin
          m_mem[mq[0].a] = mq[0].d;
          void'(mq.pop_front());
        end
        if (e_wr && write_mem) mq.push_back({mem_wadrs, result});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    @(negedge clk);
    while (init_done !== 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] dat);
    int n;
    n = 0;
    write_mem = 1'b1;
    mem_wadrs = a;
    result    = dat;
    @(negedge clk);
    while (write_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chkb("wr_accept", write_ready, 1'b1);
    step();
    write_mem = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output int stalls);
    stalls    = 0;
    read_mem  = 1'b1;
    mem_radrs = a;
    @(negedge clk);
    while (read_ready !== 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    chkb("rd_accept", read_ready, 1'b1);
    step();
    read_mem = 1'b0;
    @(negedge clk);
    chkb("rd_valid", rdata_valid, 1'b1);
    d = instruction_fetch;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int st;
    int n;

    repeat (3) @(negedge clk);
    step();
    reset     = 1'b0;
    read_mem  = 1'b1;
    mem_radrs = 11'h7FF;
    wait_init(n);
    chk("init_cycles", n, 2048);
    chkb("first_read_accept", read_ready, 1'b1);
    step();
    read_mem = 1'b0;
    @(negedge clk);
    chkb("top_word_valid", rdata_valid, 1'b1);
    chk("top_word_zero", instruction_fetch, 32'h0000_0000);
    step();

    wr(11'h010, 32'h1234_5678);
    repeat (3) step();
    rd(11'h010, d, st);
    chk("write_then_read", d, 32'h1234_5678);

    read_mem  = 1'b1;
    mem_radrs = 11'h100;
    for (int i = 0; i < 5; i++) begin
      write_mem = 1'b1;
      mem_wadrs = AW'(11'h040 + i);
      result    = DW'(32'hB000_0000 + i);
      @(negedge clk);
      if (i == 4) begin
        chkb("full_write_ready", write_ready, 1'b0);
        chkb("full_read_ready", read_ready, 1'b0);
        step();
        @(negedge clk);
        chkb("fifth_write_ready", write_ready, 1'b1);
      end
      step();
    end
    write_mem = 1'b0;
    read_mem  = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 5; i++) begin
      rd(AW'(11'h040 + i), d, st);
      chk("burst_order", d, DW'(32'hB000_0000 + i));
    end

    write_mem = 1'b1;
    mem_wadrs = 11'h020;
    result    = 32'hAAAA_0001;
    @(negedge clk);
    chkb("dup_w1_accept", write_ready, 1'b1);
    step();
    result = 32'hAAAA_0002;
`ifdef MEM_FWD_EN
    @(negedge clk);
    chkb("dup_w2_accept", write_ready, 1'b1);
    step();
    write_mem = 1'b0;
    rd(11'h020, d, st);
    chk("dup_fwd_stalls", st, 0);
    chk("dup_fwd_data", d, 32'hAAAA_0002);
`else
    read_mem  = 1'b1;
    mem_radrs = 11'h020;
    @(negedge clk);
    chkb("dup_w2_accept", write_ready, 1'b1);
    chkb("dup_stall1", read_ready, 1'b0);
    step();
    write_mem = 1'b0;
    @(negedge clk);
    chkb("dup_stall2", read_ready, 1'b0);
    step();
    @(negedge clk);
    chkb("dup_accept", read_ready, 1'b1);
    step();
    read_mem = 1'b0;
    @(negedge clk);
    chkb("dup_valid", rdata_valid, 1'b1);
    chk("dup_data", instruction_fetch, 32'hAAAA_0002);
    step();
`endif

    read_mem  = 1'b1;
    mem_radrs = 11'h030;
    write_mem = 1'b1;
    mem_wadrs = 11'h030;
    result    = 32'hFFFF_0000;
    @(negedge clk);
    chkb("rw_same_rd", read_ready, 1'b1);
    chkb("rw_same_wr", write_ready, 1'b1);
    step();
    read_mem  = 1'b0;
    write_mem = 1'b0;
    @(negedge clk);
    chkb("rw_same_valid", rdata_valid, 1'b1);
    chk("rw_same_old", instruction_fetch, 32'h0000_0000);
    step();
    rd(11'h030, d, st);
    chk("rw_same_new", d, 32'hFFFF_0000);

    repeat (3000) begin
      read_mem  = ($urandom_range(0, 1) == 1);
      write_mem = ($urandom_range(0, 3) != 0);
      mem_radrs = AW'($urandom_range(0, 15));
      mem_wadrs = AW'($urandom_range(0, 15));
      result    = $urandom;
      step();
    end
    read_mem  = 1'b0;
    write_mem = 1'b0;
    repeat (10) step();

    read_mem  = 1'b1;
    mem_radrs = 11'h200;
    for (int i = 0; i < 3; i++) begin
      write_mem = 1'b1;
      mem_wadrs = AW'(11'h050 + i);
      result    = DW'(32'hC000_0000 + i);
      @(negedge clk);
      chkb("pre_rst_rd", read_ready, 1'b1);
      chkb("pre_rst_wr", write_ready, 1'b1);
      step();
    end
    reset     = 1'b1;
    read_mem  = 1'b0;
    write_mem = 1'b0;
    @(negedge clk);
    chkb("rst_drops_read", rdata_valid, 1'b0);
    step();
    step();
    reset = 1'b0;
    repeat (100) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_init(n);
    chk("reinit_cycles", n, 2048);
    step();
    for (int i = 0; i < 3; i++) begin
      rd(AW'(11'h050 + i), d, st);
      chk("rst_discard", d, 32'h0000_0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
